// File: rtl/rd_ptr_ctrl.sv
// Read-domain pointer controller for an asynchronous FIFO: owns the read pointer, synchronises the
// incoming Gray write pointer and produces registered empty/almost_empty/count/underflow flags.
module rd_ptr_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned DEPTH       = 1 << ADDR_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 1
) (
    input  logic                  clk_B,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   g_wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   g_rd_ptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    // Threshold clamped to DEPTH so an out-of-range override cannot overflow the compare width.
    localparam logic [PW-1:0] AE_LIM = PW'((AE_THRESH > DEPTH) ? DEPTH : AE_THRESH);

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wr_bin_s;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] g_rd_ptr_q, g_rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc;

    // Plain flop chain; no logic between stages so every stage sees a single-bit-change Gray code.
    always_ff @(posedge clk_B or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= g_wr_ptr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        wr_bin_s = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin_s[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        end
    end

    always_comb begin
        rd_acc      = rd_en & ~empty_q;
        rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
        g_rd_ptr_d  = rd_ptr_d ^ (rd_ptr_d >> 1);
        count_d     = wr_bin_s - rd_ptr_d;
        empty_d     = (rd_ptr_d == wr_bin_s);
        ae_d        = (count_d <= AE_LIM);
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge clk_B or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            g_rd_ptr_q  <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            g_rd_ptr_q  <= g_rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
    assign g_rd_ptr     = g_rd_ptr_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign rd_count     = count_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed bench for rd_ptr_ctrl: a SYNC_STAGES=2 instance plus a SYNC_STAGES=3 instance for latency.
module tb_rd_ptr_ctrl;

    logic       clk_B = 1'b0;
    logic       rst = 1'b1;
    logic       rd_en = 1'b0;
    logic [3:0] g_wr_ptr = 4'd0;

    logic [2:0] rd_addr, rd_addr3;
    logic [3:0] g_rd_ptr, g_rd_ptr3;
    logic       empty, empty3, almost_empty, almost_empty3, underflow, underflow3;
    logic [3:0] rd_count, rd_count3;

    int checks = 0;
    int errors = 0;

    rd_ptr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AE_THRESH(1)) dut (
        .clk_B(clk_B), .rst(rst), .rd_en(rd_en), .g_wr_ptr(g_wr_ptr), .rd_addr(rd_addr),
        .g_rd_ptr(g_rd_ptr), .empty(empty), .almost_empty(almost_empty), .rd_count(rd_count),
        .underflow(underflow)
    );

    rd_ptr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(3), .AE_THRESH(1)) dut3 (
        .clk_B(clk_B), .rst(rst), .rd_en(rd_en), .g_wr_ptr(g_wr_ptr), .rd_addr(rd_addr3),
        .g_rd_ptr(g_rd_ptr3), .empty(empty3), .almost_empty(almost_empty3), .rd_count(rd_count3),
        .underflow(underflow3)
    );

    always #5 clk_B = ~clk_B;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] gray(input int unsigned v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk_B);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
        checks++; if (g_rd_ptr !== 4'd0) begin errors++; $display("FAIL reset_grd: got %b want 0000", g_rd_ptr); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL reset_flags: empty %b ae %b want 1 1", empty, almost_empty); end
        checks++; if (rd_count !== 4'd0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_cnt: count %0d uf %b want 0 0", rd_count, underflow); end
        rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1 || rd_count !== 4'd0) begin errors++; $display("FAIL reset_release: empty %b count %0d want 1 0", empty, rd_count); end
    endtask

    task automatic test_sync_latency();
        g_wr_ptr = 4'b0001;
        tick();  // edge 0
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sync_e0: empty %b want 1", empty); end
        tick();  // edge 1
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sync_e1: empty %b want 1", empty); end
        tick();  // edge 2
        checks++; if (empty !== 1'b0 || rd_count !== 4'd1) begin errors++; $display("FAIL sync_e2: empty %b count %0d want 0 1", empty, rd_count); end
        checks++; if (empty3 !== 1'b1) begin errors++; $display("FAIL sync3_e2: empty %b want 1", empty3); end
        tick();  // edge 3
        checks++; if (empty3 !== 1'b0 || rd_count3 !== 4'd1) begin errors++; $display("FAIL sync3_e3: empty %b count %0d want 0 1", empty3, rd_count3); end
    endtask

    task automatic test_drain();
        g_wr_ptr = gray(3);
        repeat (4) tick();
        checks++; if (rd_count !== 4'd3 || almost_empty !== 1'b0 || rd_addr !== 3'd0) begin
            errors++; $display("FAIL drain_start: count %0d ae %b addr %0d want 3 0 0", rd_count, almost_empty, rd_addr); end
        rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (rd_addr !== 3'(i) || rd_count !== 4'(3 - i) || almost_empty !== (i >= 2) || empty !== (i == 3)) begin
                errors++; $display("FAIL drain_%0d: addr %0d count %0d ae %b empty %b want %0d %0d %b %b",
                                   i, rd_addr, rd_count, almost_empty, empty, i, 3 - i, i >= 2, i == 3); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_underflow();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_idle: got %b want 0", underflow); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (underflow !== 1'b1 || rd_addr !== 3'd3 || g_rd_ptr !== 4'b0010) begin
                errors++; $display("FAIL uf_pulse_%0d: uf %b addr %0d grd %b want 1 3 0010", i, underflow, rd_addr, g_rd_ptr); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (underflow !== 1'b0 || rd_addr !== 3'd3) begin errors++; $display("FAIL uf_end: uf %b addr %0d want 0 3", underflow, rd_addr); end
    endtask

    task automatic test_wrap_full();
        logic [3:0] prev;
        for (int lap = 0; lap < 2; lap++) begin
            for (int w = 4 + 8 * lap; w < 12 + 8 * lap; w++) begin
                g_wr_ptr = gray(w);
                tick();
            end
            repeat (3) tick();
            checks++; if (rd_count !== 4'd8 || empty !== 1'b0 || almost_empty !== 1'b0) begin
                errors++; $display("FAIL full_%0d: count %0d empty %b ae %b want 8 0 0", lap, rd_count, empty, almost_empty); end
            prev = gray(3 + 8 * lap);
            rd_en = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                int unsigned p;
                p = (3 + 8 * lap + i) % 16;
                tick();
                checks++; if (rd_addr !== 3'(p % 8) || g_rd_ptr !== gray(p) || rd_count !== 4'(8 - i)) begin
                    errors++; $display("FAIL wrap_%0d_%0d: addr %0d grd %b count %0d want %0d %b %0d",
                                       lap, i, rd_addr, g_rd_ptr, rd_count, p % 8, gray(p), 8 - i); end
                checks++; if ($countones(prev ^ g_rd_ptr) != 1) begin
                    errors++; $display("FAIL gray_step_%0d_%0d: got %b after %b want one-bit change", lap, i, g_rd_ptr, prev); end
                prev = gray(p);
            end
            rd_en = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        g_wr_ptr = gray(4);
        tick();
        g_wr_ptr = gray(5);
        repeat (4) tick();
        checks++; if (rd_count !== 4'd2 || almost_empty !== 1'b0) begin errors++; $display("FAIL simul_pre: count %0d ae %b want 2 0", rd_count, almost_empty); end
        g_wr_ptr = gray(6);
        tick();
        tick();
        checks++; if (rd_count !== 4'd2) begin errors++; $display("FAIL simul_wait: count %0d want 2", rd_count); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_count !== 4'd2 || empty !== 1'b0 || rd_addr !== 3'd4 || g_rd_ptr !== 4'b0110) begin
            errors++; $display("FAIL simul_edge: count %0d empty %b addr %0d grd %b want 2 0 4 0110", rd_count, empty, rd_addr, g_rd_ptr); end
    endtask

    task automatic test_async_reset();
        rd_en = 1'b1;
        tick();
        checks++; if (rd_addr !== 3'd5) begin errors++; $display("FAIL arst_pre: addr %0d want 5", rd_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rd_addr !== 3'd0 || g_rd_ptr !== 4'd0 || rd_count !== 4'd0) begin
            errors++; $display("FAIL arst_ptr: addr %0d grd %b count %0d want 0 0000 0", rd_addr, g_rd_ptr, rd_count); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || underflow !== 1'b0) begin
            errors++; $display("FAIL arst_flags: empty %b ae %b uf %b want 1 1 0", empty, almost_empty, underflow); end
        g_wr_ptr = 4'd0;
        rd_en = 1'b0;
        #2 rst = 1'b0;
        tick();
        checks++; if (empty !== 1'b1 || rd_count !== 4'd0 || rd_addr !== 3'd0) begin
            errors++; $display("FAIL arst_release: empty %b count %0d addr %0d want 1 0 0", empty, rd_count, rd_addr); end
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_drain();
        test_underflow();
        test_wrap_full();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
